// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter
//   Shares one single-port SRAM macro between two requesters (A: AHB-side
//   glue, B: secondary master such as DMA or a boot loader). Requests are
//   arbitrated round-robin. Each granted access is sequenced with a fixed read
//   latency and completed with a one-cycle ack on the granted port.
//   Out-of-range addresses complete with an error ack and never touch the SRAM.
//
// Ports
//   clk, n_rst                 clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_be/a_wdata   port A request (held until a_ack)
//   a_ack/a_err/a_rdata        port A completion pulse, error flag, read data
//   b_*                        same as port A, for port B
//   sram_ce/sram_we/sram_addr/sram_be/sram_wdata   SRAM command (registered)
//   sram_rdata                 SRAM read data, valid RD_LAT cycles after ce
// -----------------------------------------------------------------------------
module sram_access_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [3:0]        a_be,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [3:0]        b_be,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [31:0]       b_rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  // WAIT lasts RD_LAT-1 cycles, so the counter starts one below that and the
  // capture happens on the edge where it reads zero.
  localparam logic [2:0] WAIT_INIT = (RD_LAT >= 2) ? 3'(RD_LAT - 2) : 3'd0;

  state_t            state;
  logic              last_b;   // 1: last grant went to B
  logic              cur_b;    // 1: access in flight belongs to B
  logic              cur_we;
  logic [2:0]        cnt;

  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic              sel_oor;

  // Round-robin: on a tie, the port that did not win last time is granted.
  always_comb begin
    pick_b    = b_req & (~a_req | ~last_b);
    sel_we    = pick_b ? b_we    : a_we;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_be    = pick_b ? b_be    : a_be;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    sel_oor   = (32'(sel_addr) >= NUM_WORDS);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      cur_b      <= 1'b0;
      cur_we     <= 1'b0;
      cnt        <= '0;
      a_ack      <= 1'b0;
      a_err      <= 1'b0;
      a_rdata    <= '0;
      b_ack      <= 1'b0;
      b_err      <= 1'b0;
      b_rdata    <= '0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_be    <= '0;
      sram_wdata <= '0;
    end else begin
      sram_ce <= 1'b0;
      sram_we <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_err   <= 1'b0;
      b_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            cur_b  <= pick_b;
            last_b <= pick_b;
            cur_we <= sel_we;
            if (sel_oor) begin
              state <= DONE;
              a_ack <= ~pick_b;
              b_ack <= pick_b;
              a_err <= ~pick_b;
              b_err <= pick_b;
            end else begin
              state      <= ACCESS;
              sram_ce    <= 1'b1;
              sram_we    <= sel_we;
              sram_addr  <= sel_addr;
              sram_be    <= sel_be;
              sram_wdata <= sel_wdata;
            end
          end
        end

        ACCESS: begin
          if (cur_we || RD_LAT == 1) begin
            state <= DONE;
            a_ack <= ~cur_b;
            b_ack <= cur_b;
            if (!cur_we) begin
              if (cur_b) b_rdata <= sram_rdata;
              else       a_rdata <= sram_rdata;
            end
          end else begin
            state <= WAIT;
            cnt   <= WAIT_INIT;
          end
        end

        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
            a_ack <= ~cur_b;
            b_ack <= cur_b;
            if (cur_b) b_rdata <= sram_rdata;
            else       a_rdata <= sram_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_access_arbiter
//   Self-checking bench for sram_access_arbiter. A behavioural SRAM sits on the
//   SRAM port; a transaction-level reference model (word array, round-robin
//   pointer, last read data per port) predicts grant order, ack latency, error
//   flags, SRAM command and read data. Directed cases first, then random.
// -----------------------------------------------------------------------------
module tb_sram_access_arbiter;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned NUM_WORDS = 1024;
  localparam int unsigned RD_LAT    = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              a_req = 1'b0, a_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [3:0]        a_be = '0;
  logic [31:0]       a_wdata = '0;
  logic              a_ack, a_err;
  logic [31:0]       a_rdata;
  logic              b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [3:0]        b_be = '0;
  logic [31:0]       b_wdata = '0;
  logic              b_ack, b_err;
  logic [31:0]       b_rdata;
  logic              sram_ce, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [3:0]        sram_be;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  sram_access_arbiter #(
    .ADDR_W   (ADDR_W),
    .NUM_WORDS(NUM_WORDS),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_be      (a_be),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_err     (a_err),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_be      (b_be),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_err     (b_err),
    .b_rdata   (b_rdata),
    .sram_ce   (sram_ce),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_be   (sram_be),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: samples the command on the edge, read data appears one
  // register stage later (RD_LAT = 2 counted from the ce cycle).
  logic [31:0] sram_mem [0:(1<<ADDR_W)-1];
  logic [31:0] rd_q = '0;
  initial for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = '0;
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int i = 0; i < 4; i++)
          if (sram_be[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
      end else begin
        rd_q <= sram_mem[sram_addr];
      end
    end
  end
  assign sram_rdata = rd_q;

  // Reference model state
  logic [31:0] ref_mem [0:NUM_WORDS-1];
  logic [31:0] last_rd [0:1];
  bit          last_b = 1'b1;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t mk_txn(input logic we, input int unsigned addr,
                                  input logic [3:0] be, input logic [31:0] wdata);
    txn_t t;
    t.we = we;
    t.addr = ADDR_W'(addr);
    t.be = be;
    t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we = 1'($urandom);
    if ($urandom_range(0, 7) == 0)
      t.addr = ADDR_W'($urandom_range(NUM_WORDS, (1 << ADDR_W) - 1));
    else
      t.addr = ADDR_W'($urandom_range(0, 63));
    t.be = 4'($urandom);
    t.wdata = $urandom;
    return t;
  endfunction

  // Winner of arbitration: 1 means port B.
  function automatic bit pick(input bit a, input bit b);
    if (a && b) return !last_b;
    return b;
  endfunction

  task automatic drive(input bit port, input txn_t t);
    if (port) begin
      b_req = 1'b1; b_we = t.we; b_addr = t.addr; b_be = t.be; b_wdata = t.wdata;
    end else begin
      a_req = 1'b1; a_we = t.we; a_addr = t.addr; a_be = t.be; a_wdata = t.wdata;
    end
  endtask

  task automatic drop(input bit port);
    if (port) begin
      b_req = 1'b0; b_we = 1'($urandom); b_addr = ADDR_W'($urandom);
      b_be = 4'($urandom); b_wdata = $urandom;
    end else begin
      a_req = 1'b0; a_we = 1'($urandom); a_addr = ADDR_W'($urandom);
      a_be = 4'($urandom); a_wdata = $urandom;
    end
  endtask

  // Follows one access from the grant edge to its ack. offset is the number
  // of negedges before the granting edge (0 when driven in IDLE, 1 when the
  // request waits behind a DONE cycle).
  task automatic serve(input bit port, input txn_t t, input int offset);
    int  k = 0, ce_n = 0, ce_k = 0, lat;
    bit  done = 1'b0, err;
    int unsigned idx;
    err = (32'(t.addr) >= NUM_WORDS);
    lat = err ? 1 : (t.we ? 2 : int'(RD_LAT) + 1);
    idx = 32'(t.addr);
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (sram_ce) begin
        ce_n++;
        ce_k = k;
        check_val("ce_addr", 32'(sram_addr), 32'(t.addr));
        check_val("ce_we", 32'(sram_we), 32'(t.we));
        if (t.we) begin
          check_val("ce_be", 32'(sram_be), 32'(t.be));
          check_val("ce_wdata", sram_wdata, t.wdata);
        end
      end
      if (a_ack || b_ack) done = 1'b1;
    end
    check_val("ack_seen", 32'(done), 32'd1);
    if (done) begin
      check_val("ack_port", {30'd0, a_ack, b_ack}, port ? 32'd1 : 32'd2);
      check_val("ack_lat", k, offset + lat);
      check_val("err", 32'(port ? b_err : a_err), 32'(err));
      check_val("ce_count", ce_n, err ? 0 : 1);
      if (!err) begin
        check_val("ce_pos", ce_k, offset + 1);
        if (t.we) begin
          for (int i = 0; i < 4; i++)
            if (t.be[i]) ref_mem[idx][8*i +: 8] = t.wdata[8*i +: 8];
        end else begin
          last_rd[port] = ref_mem[idx];
        end
        check_val(port ? "b_rdata" : "a_rdata", port ? b_rdata : a_rdata, last_rd[port]);
      end
    end
    last_b = port;
  endtask

  // One or two requests raised together in IDLE, each dropped after its ack.
  task automatic run(input bit a_en, input bit b_en, input txn_t ta, input txn_t tb);
    bit first;
    if (a_en) drive(1'b0, ta);
    if (b_en) drive(1'b1, tb);
    first = pick(a_en, b_en);
    serve(first, first ? tb : ta, 0);
    drop(first);
    if (a_en && b_en) begin
      serve(!first, first ? ta : tb, 1);
      drop(!first);
    end
    @(negedge clk);
  endtask

  task automatic reset_mid(input int at_k, input string tag);
    int acks = 0;
    drive(1'b0, mk_txn(1'b0, 7, 4'hF, 32'h0));
    repeat (at_k) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_val({tag, "_ce"}, 32'(sram_ce), 32'd0);
    check_val({tag, "_ack"}, {30'd0, a_ack, b_ack}, 32'd0);
    check_val({tag, "_rdata"}, a_rdata, 32'd0);
    drop(1'b0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    last_b = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack || b_ack) acks++;
    end
    check_val({tag, "_no_ack"}, acks, 0);
  endtask

  initial begin
    bit ae, be_;
    for (int i = 0; i < NUM_WORDS; i++) ref_mem[i] = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ce_we", {30'd0, sram_ce, sram_we}, 32'd0);
    check_val("rst_addr", 32'(sram_addr), 32'd0);
    check_val("rst_be", 32'(sram_be), 32'd0);
    check_val("rst_wdata", sram_wdata, 32'd0);
    check_val("rst_acks", {28'd0, a_ack, a_err, b_ack, b_err}, 32'd0);
    check_val("rst_a_rdata", a_rdata, 32'd0);
    check_val("rst_b_rdata", b_rdata, 32'd0);
    n_rst = 1'b1;

    // Both requests held from reset: A, B, A, B
    begin
      txn_t ta, tb;
      bit p;
      ta = mk_txn(1'b1, 20, 4'hF, 32'hA5A5_0001);
      tb = mk_txn(1'b0, 21, 4'hF, 32'h0);
      drive(1'b0, ta);
      drive(1'b1, tb);
      for (int i = 0; i < 4; i++) begin
        p = pick(1'b1, 1'b1);
        check_val("rr_order", 32'(p), 32'(i % 2));
        serve(p, p ? tb : ta, (i == 0) ? 0 : 1);
      end
      drop(1'b0);
      drop(1'b1);
      @(negedge clk);
    end

    // A write then read of address 5
    run(1'b1, 1'b0, mk_txn(1'b1, 5, 4'hF, 32'hDEAD_BEEF), rand_txn());
    run(1'b1, 1'b0, mk_txn(1'b0, 5, 4'h0, 32'h0), rand_txn());
    check_val("read5", a_rdata, 32'hDEAD_BEEF);

    // B read out of range
    run(1'b0, 1'b1, rand_txn(), mk_txn(1'b0, NUM_WORDS, 4'h0, 32'h0));

    // Partial write over all-ones
    run(1'b1, 1'b0, mk_txn(1'b1, 9, 4'hF, 32'hFFFF_FFFF), rand_txn());
    run(1'b1, 1'b0, mk_txn(1'b1, 9, 4'b0011, 32'h1234_5678), rand_txn());
    run(1'b0, 1'b1, rand_txn(), mk_txn(1'b0, 9, 4'h0, 32'h0));
    check_val("partial", b_rdata, 32'hFFFF_5678);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      ae = 1'($urandom);
      be_ = 1'($urandom);
      if (!ae && !be_) ae = 1'b1;
      run(ae, be_, rand_txn(), rand_txn());
    end

    // Reset in the ACCESS cycle and in the WAIT cycle of a read
    reset_mid(1, "rst_access");
    reset_mid(2, "rst_wait");
    run(1'b1, 1'b1, mk_txn(1'b0, 9, 4'h0, 32'h0), mk_txn(1'b0, 5, 4'h0, 32'h0));
    for (int i = 0; i < 20; i++) run(1'b1, 1'b1, rand_txn(), rand_txn());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
